// File: rtl/if_fetch_buffer_pkg.sv
// Shared fetch-stage definitions: bus widths, enable/reset levels and the
// default instruction buffer depth.
package if_fetch_buffer_pkg;

  localparam logic RstEnable   = 1'b1;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned InstBus     = 32;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

  localparam int unsigned IfBufDepth = 4;

endpackage

// File: rtl/if_queue_mem.sv
// Fetch queue storage: per-entry {pc, inst, filled} with independent allocate,
// fill and read ports; flush and reset clear only the filled bits.
module if_queue_mem
  import if_fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = IfBufDepth,
  parameter int unsigned ADDR_W = InstAddrBus,
  parameter int unsigned DATA_W = InstBus,
  parameter int unsigned PtrW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              alloc_en_i,
  input  logic [PtrW-1:0]   alloc_idx_i,
  input  logic [ADDR_W-1:0] alloc_pc_i,
  input  logic              fill_en_i,
  input  logic [PtrW-1:0]   fill_idx_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic [PtrW-1:0]   rd_idx_i,
  output logic              rd_filled_o,
  output logic [ADDR_W-1:0] rd_pc_o,
  output logic [DATA_W-1:0] rd_inst_o
);

  logic [DEPTH-1:0]  filled_q;
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [DATA_W-1:0] inst_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst == RstEnable || flush_i) begin
      filled_q <= '0;
    end else begin
      if (alloc_en_i) begin
        filled_q[alloc_idx_i] <= 1'b0;
      end
      if (fill_en_i) begin
        filled_q[fill_idx_i] <= 1'b1;
      end
    end
  end

  // Payload needs no reset: an entry is only ever read while its filled bit is set.
  always_ff @(posedge clk) begin
    if (alloc_en_i) begin
      pc_q[alloc_idx_i] <= alloc_pc_i;
    end
    if (fill_en_i) begin
      inst_q[fill_idx_i] <= fill_data_i;
    end
  end

  assign rd_filled_o = filled_q[rd_idx_i];
  assign rd_pc_o     = pc_q[rd_idx_i];
  assign rd_inst_o   = inst_q[rd_idx_i];

endmodule

// File: rtl/if_fetch_buffer.sv
// Instruction fetch buffer: issues one memory request at a time, queues the
// in-order responses with their PCs and hands them to decode; flush drops all.
module if_fetch_buffer
  import if_fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = IfBufDepth,
  parameter int unsigned ADDR_W = InstAddrBus,
  parameter int unsigned DATA_W = InstBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  output logic              pc_ready_o,
  input  logic              flush_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [DATA_W-1:0] id_inst_o,
  input  logic              id_stall_i
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic StIdle = 1'b0;
  localparam logic StReq  = 1'b1;

  localparam logic [CntW:0] DepthLim = (CntW + 1)'(DEPTH);

  logic              state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PtrW-1:0]   head_q, head_d;
  logic [PtrW-1:0]   tail_q, tail_d;
  logic [PtrW-1:0]   fill_q, fill_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [CntW-1:0]   pend_q, pend_d;
  logic [CntW-1:0]   discard_cnt_q, discard_cnt_d;

  logic              gnt;
  logic              accept;
  logic              alloc;
  logic              fill_en;
  logic              drop;
  logic              pop;
  logic              has_out;
  logic [CntW:0]     inflight;
  logic [CntW-1:0]   flush_disc;

  logic              rd_filled;
  logic [ADDR_W-1:0] rd_pc;
  logic [DATA_W-1:0] rd_inst;

  assign gnt     = (state_q == StReq) && imem_gnt_i;
  assign has_out = (discard_cnt_q != '0) || (pend_q != '0);

  // Responses still owed to flushed fetches share the DEPTH budget with the
  // queue, which bounds discard_cnt by DEPTH.
  assign inflight   = {1'b0, count_q} + {1'b0, discard_cnt_q};
  assign pc_ready_o = (state_q == StIdle) && (inflight < DepthLim) &&
                      (rst != RstEnable) && !flush_i;

  assign accept  = (ce_i == ChipEnable) && pc_ready_o;
  assign alloc   = gnt && !flush_i;
  assign drop    = imem_rvalid_i && (discard_cnt_q != '0);
  assign fill_en = imem_rvalid_i && (discard_cnt_q == '0) && (pend_q != '0) && !flush_i;
  assign pop     = id_valid_o && !id_stall_i && !flush_i;

  // Everything still owed by memory after this edge becomes a discard.
  assign flush_disc = discard_cnt_q + pend_q + CntW'(gnt) - CntW'(imem_rvalid_i && has_out);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    head_d        = head_q;
    tail_d        = tail_q;
    fill_d        = fill_q;
    count_d       = count_q;
    pend_d        = pend_q;
    discard_cnt_d = discard_cnt_q;

    if (flush_i) begin
      state_d       = StIdle;
      head_d        = '0;
      tail_d        = '0;
      fill_d        = '0;
      count_d       = '0;
      pend_d        = '0;
      discard_cnt_d = flush_disc;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            addr_d  = pc_i;
            state_d = StReq;
          end
        end
        StReq: begin
          if (gnt) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase

      if (alloc) begin
        tail_d = tail_q + PtrW'(1);
      end
      if (fill_en) begin
        fill_d = fill_q + PtrW'(1);
      end
      if (pop) begin
        head_d = head_q + PtrW'(1);
      end
      if (drop) begin
        discard_cnt_d = discard_cnt_q - CntW'(1);
      end
      count_d = count_q + CntW'(alloc) - CntW'(pop);
      pend_d  = pend_q + CntW'(alloc) - CntW'(fill_en);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      fill_q        <= '0;
      count_q       <= '0;
      pend_q        <= '0;
      discard_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      fill_q        <= fill_d;
      count_q       <= count_d;
      pend_q        <= pend_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  if_queue_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .PtrW   (PtrW)
  ) u_queue_mem (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .alloc_en_i  (alloc),
    .alloc_idx_i (tail_q),
    .alloc_pc_i  (addr_q),
    .fill_en_i   (fill_en),
    .fill_idx_i  (fill_q),
    .fill_data_i (imem_rdata_i),
    .rd_idx_i    (head_q),
    .rd_filled_o (rd_filled),
    .rd_pc_o     (rd_pc),
    .rd_inst_o   (rd_inst)
  );

  assign imem_req_o  = (state_q == StReq);
  assign imem_addr_o = addr_q;

  // A drained slot keeps its stale filled bit, so occupancy gates validity.
  assign id_valid_o = (count_q != '0) && rd_filled;
  assign id_pc_o    = id_valid_o ? rd_pc : '0;
  assign id_inst_o  = id_valid_o ? rd_inst : DATA_W'(ZeroWord);

  property p_rvalid_expected;
    @(posedge clk) disable iff (rst == RstEnable) imem_rvalid_i |-> has_out;
  endproperty
  assert property (p_rvalid_expected)
    else $error("if_fetch_buffer: rvalid with no outstanding fetch");

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Bench for if_fetch_buffer: in-order memory responder with configurable grant
// and response delays, and a scoreboard checked on every delivered instruction.
module tb_if_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_i = '0;
  logic        ce_i = 1'b0;
  logic        pc_ready_o;
  logic        flush_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_stall_i = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    int          gdly;
    int          rlat;
    int          lat;
  } vec_t;

  exp_t        exp_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] mem_img [logic [31:0]];
  vec_t        vecs [5];

  int   gnt_dly = 0;
  int   rsp_lat = 1;
  int   cyc = 0;
  int   wcnt = 0;
  logic rs;

  always #5 clk = ~clk;

  if_fetch_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .ce_i          (ce_i),
    .pc_ready_o    (pc_ready_o),
    .flush_i       (flush_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .id_valid_o    (id_valid_o),
    .id_pc_o       (id_pc_o),
    .id_inst_o     (id_inst_o),
    .id_stall_i    (id_stall_i)
  );

  function automatic logic [31:0] mem_of(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: grants after gnt_dly waiting cycles, returns data rsp_lat
  // cycles after the grant, strictly in order; reset abandons everything.
  always begin
    rsp_t r;
    exp_t e;
    @(posedge clk);
    rs = rst;
    #1;
    cyc++;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    if (rs) begin
      rsp_q.delete();
      wcnt = 0;
    end else begin
      if (imem_req_o) begin
        if (wcnt >= gnt_dly) begin
          imem_gnt_i = 1'b1;
          wcnt       = 0;
          r.due      = cyc + rsp_lat;
          r.data     = mem_of(imem_addr_o);
          rsp_q.push_back(r);
          e.pc   = imem_addr_o;
          e.inst = r.data;
          exp_q.push_back(e);
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = rsp_q[0].data;
        r = rsp_q.pop_front();
      end
    end
  end

  // Scoreboard: anything delivered to decode must be the oldest surviving fetch.
  always @(negedge clk) begin
    exp_t e;
    if (rst || flush_i) begin
      exp_q.delete();
    end else if (id_valid_o && !id_stall_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_delivery", {id_pc_o, id_inst_o}, 64'h0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_delivery", {id_pc_o, id_inst_o}, {e.pc, e.inst});
      end
    end else if (!id_valid_o) begin
      chk("invalid_outputs_zero", {id_pc_o, id_inst_o}, 64'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc);
    logic acc;
    acc  = 1'b0;
    ce_i = 1'b1;
    pc_i = pc;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = pc_ready_o;
      tick();
    end
    ce_i = 1'b0;
    if (!acc) chk("fetch_accept_timeout", 64'(pc), 64'hFFFF_FFFF_FFFF_FFFF);
  endtask

  task automatic wait_valid(input string name, input logic [31:0] pc, input logic [31:0] inst);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = id_valid_o;
    end
    chk({name, "_valid"}, 64'(seen), 64'd1);
    chk({name, "_pc_inst"}, {id_pc_o, id_inst_o}, {pc, inst});
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int lat;

    vecs[0] = '{pc: 32'h0000_0000, inst: 32'h3C01_1234, gdly: 1, rlat: 2, lat: 4};
    vecs[1] = '{pc: 32'h0000_0004, inst: 32'h8C22_0004, gdly: 0, rlat: 1, lat: 2};
    vecs[2] = '{pc: 32'h0000_0008, inst: 32'h0043_0820, gdly: 3, rlat: 1, lat: 5};
    vecs[3] = '{pc: 32'h0000_1000, inst: 32'hAC22_0000, gdly: 0, rlat: 4, lat: 5};
    vecs[4] = '{pc: 32'hFFFF_FFFC, inst: 32'h1000_FFFF, gdly: 2, rlat: 3, lat: 6};

    // Reset state
    settle(2);
    @(negedge clk);
    chk("rst_pc_ready", 64'(pc_ready_o), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_outputs", {28'd0, imem_req_o, id_valid_o, 2'd0, imem_addr_o},
        {28'd0, 1'b0, 1'b0, 2'd0, 32'h0});
    chk("rst_id_data", {id_pc_o, id_inst_o}, 64'h0);
    chk("rst_release_ready", 64'(pc_ready_o), 64'd1);

    // Single fetches across grant/response delays
    foreach (vecs[i]) begin
      tick();
      gnt_dly = vecs[i].gdly;
      rsp_lat = vecs[i].rlat;
      mem_img[vecs[i].pc] = vecs[i].inst;
      fetch(vecs[i].pc);
      lat = -1;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (k == 0) begin
          chk("vec_req_phase", {30'd0, imem_req_o, pc_ready_o, imem_addr_o},
              {30'd0, 1'b1, 1'b0, vecs[i].pc});
        end
        if (id_valid_o) begin
          lat = k;
          break;
        end
      end
      chk("vec_latency", 64'(lat), 64'(vecs[i].lat));
      chk("vec_pc_inst", {id_pc_o, id_inst_o}, {vecs[i].pc, vecs[i].inst});
    end
    settle(4);

    // Fill all entries under stall, then drain back-to-back
    gnt_dly    = 0;
    rsp_lat    = 1;
    id_stall_i = 1'b1;
    for (int i = 0; i < 4; i++) fetch(32'(i * 4));
    tick();
    ce_i = 1'b1;
    pc_i = 32'h10;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("full_no_req", {62'd0, pc_ready_o, imem_req_o}, 64'd0);
    end
    tick();
    ce_i = 1'b0;
    @(negedge clk);
    chk("full_head", {31'd0, id_valid_o, id_pc_o}, {31'd0, 1'b1, 32'h0});
    tick();
    id_stall_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_order", {31'd0, id_valid_o, id_pc_o}, {31'd0, 1'b1, 32'(i * 4)});
    end
    settle(4);

    // Grant withheld: request and address held, no new PC taken
    gnt_dly = 5;
    fetch(32'h8);
    ce_i = 1'b1;
    pc_i = 32'h30;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_req", {30'd0, imem_req_o, pc_ready_o, imem_addr_o},
          {30'd0, 1'b1, 1'b0, 32'h8});
    end
    tick();
    ce_i = 1'b0;
    settle(6);
    gnt_dly = 0;
    settle(4);

    // Flush with two granted fetches outstanding
    rsp_lat = 6;
    fetch(32'h20);
    fetch(32'h24);
    tick();
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_pc_ready", 64'(pc_ready_o), 64'd0);
    tick();
    flush_i = 1'b0;
    rsp_lat = 1;
    mem_img[32'h100] = 32'h2421_0001;
    fetch(32'h100);
    wait_valid("after_flush", 32'h100, 32'h2421_0001);
    settle(6);

    // Flush landing on the same edge as a grant and a response
    rsp_lat = 2;
    fetch(32'h40);
    fetch(32'h44);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    mem_img[32'h48] = 32'h3442_00FF;
    fetch(32'h48);
    wait_valid("flush_gnt_rvalid", 32'h48, 32'h3442_00FF);
    settle(6);

    // Reset while requesting with two buffered entries
    rsp_lat    = 1;
    id_stall_i = 1'b1;
    fetch(32'h60);
    fetch(32'h64);
    settle(2);
    gnt_dly = 10;
    fetch(32'h68);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_pc_ready", 64'(pc_ready_o), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_outputs", {30'd0, imem_req_o, id_valid_o, imem_addr_o}, 64'h0);
    chk("rst_mid_id_data", {id_pc_o, id_inst_o}, 64'h0);
    chk("rst_mid_ready", 64'(pc_ready_o), 64'd1);
    tick();
    id_stall_i = 1'b0;
    gnt_dly    = 0;
    fetch(32'h70);
    wait_valid("after_rst", 32'h70, mem_of(32'h70));

    settle(20);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/if_fetch_buffer.md
Name: if_fetch_buffer

Overview:
- Fetch stage directly downstream of the PC generator.
- Consumes the fetch address and chip-enable each cycle and issues requests to instruction memory over a request/grant/response handshake.
- Buffers returned instructions, tagged with their PC, in an in-order queue and presents them to the IF/ID boundary with stall support.
- Supports a pipeline flush (branch/exception) that drops queued and in-flight fetches.

Parameters:
DEPTH, 4, queue entries; power of two, 2..16; also caps outstanding plus buffered fetches.
ADDR_W, 32, instruction address width (matches InstAddrBus).
DATA_W, 32, instruction width (matches InstBus).

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous, active-high reset.
pc_i  input  ADDR_W  fetch address from the PC generator.
ce_i  input  1  fetch enable from the PC generator; high = pc_i valid.
pc_ready_o  output  1  buffer can accept pc_i this cycle; upstream holds the PC when low.
flush_i  input  1  discard all queued and in-flight fetches.
imem_req_o  output  1  memory request valid.
imem_addr_o  output  ADDR_W  memory request address.
imem_gnt_i  input  1  request accepted this cycle.
imem_rvalid_i  input  1  response data valid; responses return in request order, latency >= 1 cycle after gnt.
imem_rdata_i  input  DATA_W  response instruction.
id_valid_o  output  1  head entry holds a complete instruction.
id_pc_o  output  ADDR_W  PC of the head entry.
id_inst_o  output  DATA_W  instruction of the head entry.
id_stall_i  input  1  decode not consuming; the head is held.

Behaviour:
- Reset (rst=1 at the clock edge):
  - state=IDLE; count, head/tail/fill pointers and discard_cnt cleared.
  - imem_req_o=0, imem_addr_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=0.
  - pc_ready_o=0 while rst is high.
  - Reset mid-transaction abandons everything; late responses after reset are not tracked.
- Request FSM:
  - IDLE:
    - pc_ready_o = (count < DEPTH) and not rst.
    - ce_i and pc_ready_o: latch pc_i into imem_addr_o, go to REQ.
  - REQ:
    - imem_req_o=1 and imem_addr_o stable until imem_gnt_i.
    - On gnt: allocate a tail entry {pc=imem_addr_o, filled=0}, count+1, go to IDLE.
    - pc_ready_o=0 in REQ.
  - Sustained rate: one fetch per 2 cycles.
- Response handling:
  - imem_rvalid_i with discard_cnt>0: drop the data, discard_cnt-1.
  - Otherwise write imem_rdata_i into the oldest unfilled entry (fill pointer), set filled, fill pointer +1.
  - rvalid with no unfilled entry and discard_cnt=0 is a protocol error: ignore, and flag it with a sim-only assertion.
- Output and pop:
  - id_valid_o = head entry filled; id_pc_o and id_inst_o come from the head entry, 0 when not valid.
  - Pop when id_valid_o and not id_stall_i: head+1, count-1.
  - Allocate and pop in the same cycle leaves count unchanged.
  - A response may fill the head entry and that entry becomes visible the next cycle, never combinationally.
- Flush (flush_i=1, priority over everything except rst):
  - All entries invalidated; count=0; head=tail=fill=0.
  - state to IDLE; an ungranted request is withdrawn. Dropping req before gnt is legal only on flush.
  - discard_cnt = allocated-unfilled entries + (1 if gnt this cycle) − (1 if rvalid this cycle) + current discard_cnt.
  - The pop and fill of the flush cycle are suppressed.
  - pc_ready_o=0 in the flush cycle; new fetches may start next cycle while discard_cnt>0.
- Pointers are log2(DEPTH) bits, wrapping naturally. count is log2(DEPTH)+1 bits; it never exceeds DEPTH.
- discard_cnt is log2(DEPTH)+1 bits; it never exceeds DEPTH.

Decomposition:
- Use the team's shared define header: RstEnable, ChipEnable/ChipDisable, InstAddrBus, InstBus, ZeroWord. Add IfBufDepth as the default DEPTH.
- Request FSM state encodings (IDLE=1'b0, REQ=1'b1) are local.
- One natural sub-module: if_queue_mem. It holds the DEPTH x (ADDR_W+DATA_W+1) storage with separate allocate, fill and read ports plus a flush-clear of the valid/filled bits.

Test Plan:
- Reset then ce_i=1, pc_i=0x0, gnt the cycle after req, rvalid 2 cycles later with 0x3C011234 -> id_valid_o=1, id_pc_o=0x0, id_inst_o=0x3C011234 three cycles after gnt; pc_ready_o=0 during REQ.
- id_stall_i=1 held, fetch 0x0..0x10 with 1-cycle response -> 4 entries fill; pc_ready_o=0 with count=4, no 5th req; release stall -> PCs 0x0, 0x4, 0x8, 0xC delivered in order on consecutive cycles.
- gnt withheld 5 cycles -> imem_req_o=1 and imem_addr_o=0x8 stable throughout; no new PC accepted.
- Two fetches granted (0x20, 0x24), flush_i before either response, then fetch 0x100 -> first two rvalids dropped; id_pc_o=0x100 with its own data.
- flush_i in the same cycle as gnt and rvalid -> discard_cnt correct, no stale instruction ever reaches id_valid_o.
- rst asserted while in REQ with 2 entries -> next cycle all outputs 0 and id_valid_o=0; pc_ready_o=1 after rst drops.
